data_timer: RTL and testbench

DATA_TIMER -- requirements
Module: data_timer

---
 rtl/data_timer_if.sv | 21 ++
 rtl/data_timer.sv | 133 +++++++++++++
 tb/tb_data_timer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/data_timer_if.sv
// Core data-bus port bundle for data_timer: chip enable, write enable, address,
// byte-lane select, write/read data and the level interrupt back to the core.
interface data_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        int_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, int_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, int_o
  );
endinterface

// File: rtl/data_timer.sv
// 32-bit down-counting timer with CTRL/LOAD/COUNT/STATUS registers; optional TIMER_PRESCALE_EN macro.
// Writes land on the next rising edge, reads and int_o are combinational; no backpressure, always ready.
module data_timer (
  input  logic        clk,
  input  logic        rst,
  data_timer_if.slave bus
);
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic [7:0]  presc_rd;
  logic [31:0] ctrl_rd, ctrl_wr, load_wr;
  logic        wr_en, wr_ctrl, wr_load, wr_status, tick;
  logic        unused_bits;

  assign wr_en     = bus.ce & bus.we;
  assign wr_ctrl   = wr_en && (bus.addr[3:2] == A_CTRL);
  assign wr_load   = wr_en && (bus.addr[3:2] == A_LOAD);
  assign wr_status = wr_en && (bus.addr[3:2] == A_STATUS);

  assign ctrl_rd = {16'h0, presc_rd, 5'h0, ie_q, ar_q, en_q};
  assign ctrl_wr = lane_merge(ctrl_rd, bus.data_i, bus.sel);
  assign load_wr = lane_merge(load_q, bus.data_i, bus.sel);

  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], ctrl_wr[31:3]};

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc_q, presc_d, psc_q, psc_d;

  assign presc_rd = presc_q;
  // >= rather than == so lowering PRESC mid-count never waits for an 8-bit wrap
  assign tick     = en_q && (psc_q >= presc_q);

  always_comb begin
    presc_d = wr_ctrl ? ctrl_wr[15:8] : presc_q;
    psc_d   = (!en_q || tick) ? 8'h00 : psc_q + 8'h01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= 8'h00;
      psc_q   <= 8'h00;
    end else begin
      presc_q <= presc_d;
      psc_q   <= psc_d;
    end
  end
`else
  assign presc_rd = 8'h00;
  assign tick     = en_q;
`endif

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    load_d  = load_q;
    count_d = count_q;

    // clear is evaluated before expiry so a same-cycle set wins
    if (wr_status && bus.sel[0] && bus.data_i[0]) exp_d = 1'b0;

    if (tick) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'h1;
      end else begin
        exp_d = 1'b1;
        if (ar_q) count_d = load_q;
        else      en_d    = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d = ctrl_wr[0];
      ar_d = ctrl_wr[1];
      ie_d = ctrl_wr[2];
      if (!en_q && ctrl_wr[0]) count_d = load_q;
    end

    if (wr_load) begin
      load_d = load_wr;
      if (!en_q) count_d = load_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= 32'h0;
      count_q <= 32'h0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    bus.data_o = 32'h0;
    if (bus.ce && !bus.we) begin
      case (bus.addr[3:2])
        A_CTRL:   bus.data_o = ctrl_rd;
        A_LOAD:   bus.data_o = load_q;
        A_COUNT:  bus.data_o = count_q;
        default:  bus.data_o = {31'h0, exp_q};
      endcase
    end
  end

  assign bus.int_o = exp_q & ie_q;
endmodule

// File: tb/tb_data_timer.sv
// Directed bench for data_timer: register access, one-shot, auto-reload, collisions, reset and prescale.
module tb_data_timer;
  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_LOAD   = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_STATUS = 32'hC;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_timer_if bus ();

  data_timer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d; bus.sel = s;
    @(posedge clk);
    #1;
    bus.ce = 1'b0; bus.we = 1'b0; bus.sel = 4'h0; bus.data_i = 32'h0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    chk(tag, bus.data_o, exp_v);
    bus.ce = 1'b0;
  endtask

  task automatic intchk(input string tag, input logic exp_v);
    chk(tag, {31'h0, bus.int_o}, {31'h0, exp_v});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.sel = 4'h0; bus.data_i = 32'h0;
    #3;
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    rdchk("rst_load", A_LOAD, 32'h0);
    rdchk("rst_count", A_COUNT, 32'h0);
    rdchk("rst_status", A_STATUS, 32'h0);
    intchk("rst_int", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // one-shot with interrupt enabled
    wr(A_LOAD, 32'd3, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    rdchk("os_cnt3", A_COUNT, 32'd3);
    step(1); rdchk("os_cnt2", A_COUNT, 32'd2);
    step(1); rdchk("os_cnt1", A_COUNT, 32'd1);
    step(1); rdchk("os_cnt0", 32'h1000_0008, 32'd0);
    rdchk("os_exp_pre", A_STATUS, 32'h0);
    intchk("os_int_pre", 1'b0);
    step(1);
    rdchk("os_exp", A_STATUS, 32'h1);
    intchk("os_int", 1'b1);
    rdchk("os_ctrl_en0", A_CTRL, 32'h4);
    step(2); rdchk("os_no_wrap", A_COUNT, 32'd0);
    wr(A_STATUS, 32'h1, 4'hF);
    rdchk("os_clr", A_STATUS, 32'h0);
    intchk("os_int_clr", 1'b0);

    // byte lanes, ignored writes, read gating
    wr(A_LOAD, 32'h0, 4'hF);
    wr(A_LOAD, 32'hAABB_CCDD, 4'b0101);
    rdchk("bl_load", A_LOAD, 32'h00BB_00DD);
    rdchk("bl_count_copy", A_COUNT, 32'h00BB_00DD);
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = A_LOAD; #1;
    chk("bl_ce0", bus.data_o, 32'h0);
    bus.ce = 1'b1; bus.we = 1'b1; bus.sel = 4'h0; #1;
    chk("bl_we1", bus.data_o, 32'h0);
    bus.ce = 1'b0; bus.we = 1'b0;
    wr(A_LOAD, 32'hFFFF_FFFF, 4'h0);
    rdchk("bl_sel0", A_LOAD, 32'h00BB_00DD);
    wr(A_COUNT, 32'h1234, 4'hF);
    rdchk("bl_count_ro", A_COUNT, 32'h00BB_00DD);

    // auto-reload, IE=0
    wr(A_LOAD, 32'd2, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    rdchk("ar_c2a", A_COUNT, 32'd2);
    step(1); rdchk("ar_c1a", A_COUNT, 32'd1);
    step(1); rdchk("ar_c0a", A_COUNT, 32'd0);
    rdchk("ar_exp0", A_STATUS, 32'h0);
    step(1); rdchk("ar_c2b", A_COUNT, 32'd2);
    rdchk("ar_exp1", A_STATUS, 32'h1);
    rdchk("ar_en", A_CTRL, 32'h3);
    intchk("ar_int", 1'b0);
    step(1); rdchk("ar_c1b", A_COUNT, 32'd1);
    step(1); rdchk("ar_c0b", A_COUNT, 32'd0);
    step(1); rdchk("ar_c2c", A_COUNT, 32'd2);
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STATUS, 32'h1, 4'hF);
    rdchk("ar_stop_count", A_COUNT, 32'd1);
    rdchk("ar_stop_exp", A_STATUS, 32'h0);

    // clear colliding with expiry
    wr(A_LOAD, 32'd1, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    step(1); rdchk("cc_cnt0", A_COUNT, 32'd0);
    wr(A_STATUS, 32'h1, 4'hF);
    rdchk("cc_set_wins", A_STATUS, 32'h1);
    intchk("cc_int1", 1'b1);
    wr(A_STATUS, 32'h1, 4'hF);
    rdchk("cc_clr", A_STATUS, 32'h0);
    intchk("cc_int0", 1'b0);

    // LOAD=0 auto-reload expires every tick; CTRL write on expiry
    wr(A_LOAD, 32'd0, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    step(1);
    rdchk("z_exp", A_STATUS, 32'h1);
    wr(A_STATUS, 32'h1, 4'hF);
    rdchk("z_every_tick", A_STATUS, 32'h1);
    wr(A_CTRL, 32'h4, 4'hF);
    rdchk("cw_ctrl_bus_wins", A_CTRL, 32'h4);
    rdchk("cw_exp", A_STATUS, 32'h1);
    intchk("cw_int", 1'b1);
    wr(A_STATUS, 32'h1, 4'hF);
    wr(A_CTRL, 32'h0, 4'hF);

    // LOAD write while running, then reset mid-count
    wr(A_LOAD, 32'd100, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_LOAD, 32'd50, 4'hF);
    rdchk("lr_count_kept", A_COUNT, 32'd99);
    rdchk("lr_load", A_LOAD, 32'd50);
    wr(A_LOAD, 32'd100, 4'hF);
    step(8);
    rdchk("rm_count90", A_COUNT, 32'd90);
    #3;
    rst_n = 1'b0;
    #1;
    rdchk("rm_ctrl", A_CTRL, 32'h0);
    rdchk("rm_load", A_LOAD, 32'h0);
    rdchk("rm_count", A_COUNT, 32'h0);
    rdchk("rm_status", A_STATUS, 32'h0);
    intchk("rm_int", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    rdchk("rm_idle_count", A_COUNT, 32'h0);
    rdchk("rm_idle_ctrl", A_CTRL, 32'h0);

    // prescale
    wr(A_LOAD, 32'd1, 4'hF);
    wr(A_CTRL, 32'h0301, 4'hF);
`ifdef TIMER_PRESCALE_EN
    rdchk("ps_ctrl", A_CTRL, 32'h0301);
    step(3); rdchk("ps_hold", A_COUNT, 32'd1);
    step(1); rdchk("ps_dec", A_COUNT, 32'd0);
    step(3); rdchk("ps_exp_pre", A_STATUS, 32'h0);
    step(1); rdchk("ps_exp", A_STATUS, 32'h1);
    rdchk("ps_ctrl_end", A_CTRL, 32'h0300);
`else
    rdchk("ps_ctrl", A_CTRL, 32'h0001);
    step(1); rdchk("ps_dec", A_COUNT, 32'd0);
    rdchk("ps_exp_pre", A_STATUS, 32'h0);
    step(1); rdchk("ps_exp", A_STATUS, 32'h1);
    rdchk("ps_ctrl_end", A_CTRL, 32'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
